// File: rtl/seq_muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit: operation encoding and FSM states.
package seq_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'd0,
        OP_MULS = 2'd1,
        OP_DIVU = 2'd2,
        OP_DIVS = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic op_is_div(op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/seq_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// The divide branch exists only when SEQ_MULDIV_DIV_EN is defined.
module seq_muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef SEQ_MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

`ifdef SEQ_MULDIV_DIV_EN
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {hi, lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd};
`endif

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], lo[WIDTH-1:1]};
`ifdef SEQ_MULDIV_DIV_EN
        if (is_div) begin
            // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
            if (!diff[WIDTH]) begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential WIDTH-bit multiply/divide unit with valid/ready handshakes on both sides.
// Define SEQ_MULDIV_DIV_EN to include the divide datapath; otherwise divide ops return 0.
module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state;
    state_e             state_next;
    op_e                op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   opnd;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res;
    logic               neg_rem;
    logic [2*WIDTH-1:0] result_q;
    logic               div_zero_q;

    logic               is_div;
    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;

    assign is_div = op_is_div(op_reg);
    assign sgn_op = op_is_signed(op_reg);
    assign a_mag  = (sgn_op && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_mag  = (sgn_op && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    assign prod   = {hi, lo};

    seq_muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
`ifdef SEQ_MULDIV_DIV_EN
        .is_div  (is_div),
`endif
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = ST_LOAD;
            ST_LOAD: begin
`ifdef SEQ_MULDIV_DIV_EN
                if (is_div && (b_reg == '0)) state_next = ST_DONE;
                else                         state_next = ST_ITER;
`else
                state_next = is_div ? ST_DONE : ST_ITER;
`endif
            end
            ST_ITER: if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // NOTE: the datapath has no memories, so every register takes a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= OP_MULU;
            a_reg      <= '0;
            b_reg      <= '0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            cnt        <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg <= op_e'(op);
                        a_reg  <= a;
                        b_reg  <= b;
                    end
                end
                ST_LOAD: begin
                    // Multiply keeps the multiplier in lo; divide keeps the dividend there.
                    hi         <= '0;
                    lo         <= is_div ? a_mag : b_mag;
                    opnd       <= is_div ? b_mag : a_mag;
                    cnt        <= CNT_W'(WIDTH - 1);
                    neg_res    <= sgn_op && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    neg_rem    <= sgn_op && a_reg[WIDTH-1];
                    div_zero_q <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
                    if (is_div && (b_reg == '0)) begin
                        result_q   <= {a_reg, {WIDTH{1'b1}}};
                        div_zero_q <= 1'b1;
                    end
`else
                    if (is_div) result_q <= '0;
`endif
                end
                ST_ITER: begin
                    hi <= step_hi;
                    lo <= step_lo;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                ST_FIX: begin
`ifdef SEQ_MULDIV_DIV_EN
                    if (is_div) begin
                        result_q <= {(neg_rem ? -hi : hi), (neg_res ? -lo : lo)};
                    end else begin
                        result_q <= neg_res ? -prod : prod;
                    end
`else
                    result_q <= neg_res ? -prod : prod;
`endif
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv at WIDTH = 32; follows SEQ_MULDIV_DIV_EN.
module tb_seq_muldiv;

    localparam int W = 32;
`ifdef SEQ_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int LAT_MUL = W + 3;
    localparam int LAT_DZ  = 2;
    localparam int LAT_DIV = DIV_EN ? LAT_MUL : LAT_DZ;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     op = 2'd0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           div_zero;
    logic           busy;

    int checks = 0;
    int failures = 0;

    seq_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called #1 after a rising edge with the unit idle; the latency count includes the accepting edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [63:0] exp_res,
                          input logic exp_dz, input int exp_lat);
        int n;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = ~o;
        a = ~x;
        b = ~y;
        check({tag, ":busy"}, 64'({busy, in_ready}), 64'(2'b10));
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":out_valid"}, 64'(out_valid), 64'(1));
        check({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check({tag, ":result"}, result, exp_res);
        check({tag, ":div_zero"}, 64'(div_zero), 64'(exp_dz));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":back_idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic        stable;
        logic        seen;
        int          n;

        #1;
        check("reset:outputs", 64'({in_ready, out_valid, busy, div_zero}), 64'(4'b1000));
        check("reset:result", result, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mulu_b5_d",  2'd0, 32'h0000_00B5, 32'h0000_000D, 64'h0000_0000_0000_0931, 1'b0, LAT_MUL);
        run_op("mulu_max",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, LAT_MUL);
        run_op("muls_m1",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, LAT_MUL);
        run_op("muls_m3_5",  2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, LAT_MUL);
        run_op("muls_minsq", 2'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, LAT_MUL);
        run_op("mulu_zero",  2'd0, 32'h0000_0000, 32'h1234_5678, 64'h0, 1'b0, LAT_MUL);

        run_op("divu_b5_d",  2'd2, 32'h0000_00B5, 32'h0000_000D,
               DIV_EN ? 64'h0000_000C_0000_000D : 64'h0, 1'b0, LAT_DIV);
        run_op("divs_neg_a", 2'd3, 32'hFFFF_FF4B, 32'h0000_000D,
               DIV_EN ? 64'hFFFF_FFF4_FFFF_FFF3 : 64'h0, 1'b0, LAT_DIV);
        run_op("divs_neg_b", 2'd3, 32'h0000_00B5, 32'hFFFF_FFF3,
               DIV_EN ? 64'h0000_000C_FFFF_FFF3 : 64'h0, 1'b0, LAT_DIV);
        run_op("divu_small", 2'd2, 32'h0000_0007, 32'h0000_0009,
               DIV_EN ? 64'h0000_0007_0000_0000 : 64'h0, 1'b0, LAT_DIV);
        run_op("divu_by0",   2'd2, 32'h0000_1234, 32'h0000_0000,
               DIV_EN ? 64'h0000_1234_FFFF_FFFF : 64'h0, DIV_EN, LAT_DZ);
        run_op("divs_by0",   2'd3, 32'hFFFF_FF4B, 32'h0000_0000,
               DIV_EN ? 64'hFFFF_FF4B_FFFF_FFFF : 64'h0, DIV_EN, LAT_DZ);
        run_op("divs_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF,
               DIV_EN ? 64'h0000_0000_8000_0000 : 64'h0, 1'b0, LAT_DIV);

        // Consumer stalls for 10 cycles while a new request is pending.
        in_valid = 1'b1;
        op = 2'd0;
        a = 32'h0000_1000;
        b = 32'h0000_0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall:latency", 64'(n), 64'(LAT_MUL));
        in_valid = 1'b1;
        a = 32'h0000_0005;
        b = 32'h0000_0005;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== 64'h0000_0000_0001_0000 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("stall:stable", 64'(stable), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall:no_same_edge_accept", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset pulse in the middle of the iteration phase.
        in_valid = 1'b1;
        op = 2'd0;
        a = 32'd7;
        b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset:busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midreset:outputs", 64'({in_ready, out_valid, busy, div_zero}), 64'(4'b1000));
        check("midreset:result", result, 64'h0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midreset:no_out_valid", 64'(seen), 64'(0));
        run_op("mulu_3_4", 2'd0, 32'd3, 32'd4, 64'd12, 1'b0, LAT_MUL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  unit idle, request accepted when in_valid && in_ready.
REQ-006 Port: op  input  2  0 MULU, 1 MULS, 2 DIVU, 3 DIVS.
REQ-007 Port: a  input  WIDTH  multiplicand / dividend.
REQ-008 Port: b  input  WIDTH  multiplier / divisor.
REQ-009 Port: out_valid  output  1  result valid, held until taken.
REQ-010 Port: out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-011 Port: result  output  2*WIDTH  product, or {remainder, quotient} for divide.
REQ-012 Port: div_zero  output  1  qualifies result; divide with b == 0.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, LOAD, ITER, FIX, DONE; in_ready high only in IDLE.
REQ-015 IDLE -> LOAD on accept; a, b, op registered; signed ops take operand magnitudes in LOAD.
REQ-016 LOAD -> ITER; ITER runs exactly WIDTH cycles, one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle, counter counts WIDTH-1 down to 0.
REQ-017 ITER -> FIX; FIX applies sign: product negated if sign(a) != sign(b); quotient negated if sign(a) != sign(b); remainder takes sign of a.
REQ-018 FIX -> DONE; out_valid high in DONE only; result and div_zero stable while out_valid && !out_ready.
REQ-019 Normal latency: out_valid first high WIDTH+3 rising edges after the accepting edge.
REQ-020 DONE -> IDLE on out_valid && out_ready; no new request accepted on that same edge.
REQ-021 Divide with b == 0: LOAD -> DONE directly; quotient all ones, remainder = a, div_zero = 1; out_valid 2 edges after accept.
REQ-022 DIVS with a == most-negative and b == all-ones: quotient = a, remainder = 0, div_zero = 0, normal latency.
REQ-023 MUL results are full 2*WIDTH bits, no truncation; unsigned ops ignore operand MSB sign.
REQ-024 in_valid, op, a, b ignored while in_ready is low.

Reset
REQ-025 rst_n low forces IDLE asynchronously: in_ready = 1, out_valid = 0, busy = 0, result = 0, div_zero = 0, counter = 0.
REQ-026 Reset mid-operation discards the operation; no out_valid produced for it.

Configuration
REQ-027 Macro SEQ_MULDIV_DIV_EN defined: divide datapath and REQ-021/022 present.
REQ-028 SEQ_MULDIV_DIV_EN undefined: no divide hardware; op 2/3 go LOAD -> DONE, result = 0, div_zero = 0; MUL behaviour and latency unchanged.

Structure
REQ-029 Shared package seq_muldiv_pkg holds op encoding enum and FSM state typedef.
REQ-030 One sub-module seq_muldiv_step: combinational single-iteration shift-add/shift-subtract step, instanced once.

Verification (WIDTH = 32)
REQ-031 MULU a=0x000000B5, b=0x0000000D -> result 0x0000000000000931, out_valid on edge 35 after accept.
REQ-032 MULU a=b=0xFFFFFFFF -> 0xFFFFFFFE00000001; MULS same operands -> 0x0000000000000001.
REQ-033 DIVU a=0xB5, b=0xD -> result {0x0000000C, 0x0000000D}; DIVS a=0xFFFFFF4B (-181), b=0xD -> {0xFFFFFFF4, 0xFFFFFFF3}.
REQ-034 DIVU a=0x1234, b=0 -> {0x00001234, 0xFFFFFFFF}, div_zero=1, out_valid 2 edges after accept; DIVS 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
REQ-035 out_ready held low 10 cycles in DONE -> result stable, in_ready low; then one-cycle out_ready -> IDLE next edge.
REQ-036 rst_n pulsed low during ITER -> immediate IDLE outputs, out_valid never asserted; following MULU 3*4 returns 12.
